hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32 core.
- Decides per cycle whether PC/IF_ID hold, IF_ID flushes, ID_EX takes a bubble (its stall input zeroes controls), or EX_MEM/MEM_WB freeze during a multi-cycle DRAM access.
- Also produces EX-stage forwarding selects and a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32 core: load-use stalls, branch flushes,
// DRAM wait freezes with timeout, EX-stage forwarding selects and a stall-cycle counter.
module hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_wR,
   input  logic             ex_rf_we,
   input  logic [1:0]       ex_wd_sel,
   input  logic             ex_pc_sel,
   input  logic [4:0]       mem_wR,
   input  logic             mem_rf_we,
   input  logic [4:0]       wb_wR,
   input  logic             wb_rf_we,
   input  logic             dram_req,
   input  logic             dram_ack,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_stall,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err_timeout
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MEM_WAIT   = 2'd1,
      FLUSH_PEND = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_t            state;
   state_t            state_nxt;
   logic              pending;
   logic              pending_nxt;
   logic [TO_W-1:0]   to_cnt;
   logic [TO_W-1:0]   to_cnt_nxt;
   logic              timeout_hit;
   logic              load_use;

   // MEM result is the younger value, so it wins over WB; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] m_wr, input logic m_we,
                                          input logic [4:0] w_wr, input logic w_we);
      logic [1:0] sel;
      if (m_we && (m_wr != 5'd0) && (m_wr == rs)) begin
         sel = 2'b01;
      end else if (w_we && (w_wr != 5'd0) && (w_wr == rs)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Forwarding selects for both EX operands.
   always_comb begin
      fwd_a_sel = fwd_sel(ex_rs1, mem_wR, mem_rf_we, wb_wR, wb_rf_we);
      fwd_b_sel = fwd_sel(ex_rs2, mem_wR, mem_rf_we, wb_wR, wb_rf_we);
   end

   // Load in EX whose destination is read by the instruction in ID.
   always_comb begin
      load_use = (ex_wd_sel == 2'b01) && ex_rf_we && (ex_wR != 5'd0) &&
                 ((id_rs1_used && (id_rs1 == ex_wR)) || (id_rs2_used && (id_rs2 == ex_wR)));
   end

   // Next-state and same-cycle pipeline control.
   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_stall = 1'b0;
      state_nxt    = state;
      pending_nxt  = pending;
      to_cnt_nxt   = {TO_W{1'b0}};
      timeout_hit  = 1'b0;
      case (state)
         RUN: begin
            // A taken branch discards the instruction a load-use stall would hold.
            if (ex_pc_sel) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (load_use) begin
               pc_stall     = 1'b1;
               if_id_stall  = 1'b1;
               id_ex_bubble = 1'b1;
            end else begin
               id_ex_bubble = 1'b0;
            end
            if (dram_req && !dram_ack) begin
               state_nxt   = MEM_WAIT;
               pending_nxt = ex_pc_sel;
            end else begin
               state_nxt   = RUN;
            end
         end
         MEM_WAIT: begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            pending_nxt  = pending | ex_pc_sel;
            if (dram_ack) begin
               state_nxt = pending_nxt ? FLUSH_PEND : RUN;
            end else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = pending_nxt ? FLUSH_PEND : RUN;
            end else begin
               to_cnt_nxt  = to_cnt + TO_W'(1);
            end
         end
         FLUSH_PEND: begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pending_nxt  = 1'b0;
            state_nxt    = RUN;
         end
         default: begin
            state_nxt   = RUN;
            pending_nxt = 1'b0;
         end
      endcase
   end

   // State, pending flush flag and DRAM timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         pending <= 1'b0;
         to_cnt  <= {TO_W{1'b0}};
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         to_cnt  <= to_cnt_nxt;
      end
   end

   // Saturating stall counter and sticky timeout error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt   <= {CNT_W{1'b0}};
         err_timeout <= 1'b0;
      end else begin
         if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end else begin
            stall_cnt <= stall_cnt;
         end
         err_timeout <= err_timeout | timeout_hit;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (small counter width and timeout so the
// saturation and timeout boundaries are reachable quickly).
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_wR, mem_wR, wb_wR;
   logic id_rs1_used, id_rs2_used, ex_rf_we, ex_pc_sel, mem_rf_we, wb_rf_we;
   logic [1:0] ex_wd_sel;
   logic dram_req, dram_ack;
   logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, err_timeout;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic [CNT_W-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall}
   logic [4:0] ctl;
   assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall};

   localparam logic [4:0] C_IDLE = 5'b00000;
   localparam logic [4:0] C_LU   = 5'b11010;
   localparam logic [4:0] C_BR   = 5'b00110;
   localparam logic [4:0] C_WAIT = 5'b11001;

   hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we),
      .ex_wd_sel(ex_wd_sel), .ex_pc_sel(ex_pc_sel),
      .mem_wR(mem_wR), .mem_rf_we(mem_rf_we), .wb_wR(wb_wR), .wb_rf_we(wb_rf_we),
      .dram_req(dram_req), .dram_ack(dram_ack),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_wR = 5'd0; ex_rf_we = 1'b0;
      ex_wd_sel = 2'b00; ex_pc_sel = 1'b0;
      mem_wR = 5'd0; mem_rf_we = 1'b0; wb_wR = 5'd0; wb_rf_we = 1'b0;
      dram_req = 1'b0; dram_ack = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // ld x5 in EX, add x6,x5,x1 in ID
   task automatic set_load_use();
      ex_wd_sel = 2'b01; ex_rf_we = 1'b1; ex_wR = 5'd5;
      id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd1; id_rs2_used = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_IDLE); end
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_timeout); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use();
      #1;
      checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_stall got %b exp %b", ctl, C_LU); end
      step();
      clear_inputs();
      #1;
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_release got %b exp %b", ctl, C_IDLE); end
      checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
   endtask

   task automatic test_no_stall();
      do_reset();
      ex_wd_sel = 2'b01; ex_rf_we = 1'b1; ex_wR = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
      #1;
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_x0 got %b exp %b", ctl, C_IDLE); end
      ex_wR = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; id_rs2_used = 1'b0;
      #1;
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_rs2_unused got %b exp %b", ctl, C_IDLE); end
      id_rs2_used = 1'b1;
      #1;
      checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2_used got %b exp %b", ctl, C_LU); end
   endtask

   task automatic test_branch_priority();
      do_reset();
      set_load_use();
      ex_pc_sel = 1'b1;
      #1;
      checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_over_lu got %b exp %b", ctl, C_BR); end
      step();
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL br_cnt got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_dram_wait();
      do_reset();
      dram_req = 1'b1;
      #1;
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL dram_entry got %b exp %b", ctl, C_IDLE); end
      step();
      dram_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dram_ack = (i == 2);
         #1;
         checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL dram_wait%0d got %b exp %b", i, ctl, C_WAIT); end
         step();
      end
      dram_ack = 1'b0;
      #1;
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL dram_done got %b exp %b", ctl, C_IDLE); end
      checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL dram_cnt got %0d exp 3", stall_cnt); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL dram_err got %b exp 0", err_timeout); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      dram_req = 1'b1; dram_ack = 1'b1;
      #1;
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reqack_same got %b exp %b", ctl, C_IDLE); end
      step();
      clear_inputs();
      #1;
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reqack_after got %b exp %b", ctl, C_IDLE); end
      checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reqack_cnt got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_pending_flush();
      do_reset();
      dram_req = 1'b1; ex_pc_sel = 1'b1;
      #1;
      checks++; if (ctl !== C_BR) begin errors++; $display("FAIL pend_entry got %b exp %b", ctl, C_BR); end
      step();
      dram_req = 1'b0; ex_pc_sel = 1'b0;
      #1;
      checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL pend_wait got %b exp %b", ctl, C_WAIT); end
      step();
      dram_ack = 1'b1;
      step();
      dram_ack = 1'b0;
      #1;
      checks++; if (ctl !== C_BR) begin errors++; $display("FAIL pend_flush got %b exp %b", ctl, C_BR); end
      step();
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL pend_run got %b exp %b", ctl, C_IDLE); end
   endtask

   task automatic test_timeout();
      do_reset();
      dram_req = 1'b1;
      step();
      dram_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (ctl !== C_WAIT || err_timeout !== 1'b0) begin
            errors++; $display("FAIL to_wait%0d got ctl %b err %b exp %b err 0", i, ctl, err_timeout, C_WAIT);
         end
         step();
      end
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err_timeout); end
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL to_run got %b exp %b", ctl, C_IDLE); end
      checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL to_cnt got %0d exp 4", stall_cnt); end
      step();
      step();
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", err_timeout); end
      // reset in the middle of a second wait
      dram_req = 1'b1;
      step();
      dram_req = 1'b0;
      step();
      checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL rstw_wait got %b exp %b", ctl, C_WAIT); end
      rst_n = 1'b0;
      #1;
      checks++; if (ctl !== C_IDLE || stall_cnt !== 4'd0 || err_timeout !== 1'b0) begin
         errors++; $display("FAIL rstw_clear got ctl %b cnt %0d err %b exp 00000 0 0", ctl, stall_cnt, err_timeout);
      end
      rst_n = 1'b1;
      step();
      checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL rstw_run got %b exp %b", ctl, C_IDLE); end
   endtask

   task automatic test_saturation();
      do_reset();
      set_load_use();
      for (int i = 0; i < 20; i++) step();
      checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL cnt_sat got %0d exp 15", stall_cnt); end
   endtask

   task automatic test_forwarding();
      do_reset();
      mem_wR = 5'd7; wb_wR = 5'd7; mem_rf_we = 1'b1; wb_rf_we = 1'b1; ex_rs1 = 5'd7; ex_rs2 = 5'd3;
      #1;
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin errors++; $display("FAIL fwd_mem got %b exp 0100", {fwd_a_sel, fwd_b_sel}); end
      mem_rf_we = 1'b0; ex_rs2 = 5'd7;
      #1;
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin errors++; $display("FAIL fwd_wb got %b exp 1010", {fwd_a_sel, fwd_b_sel}); end
      mem_rf_we = 1'b1; mem_wR = 5'd0; wb_wR = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
      #1;
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL fwd_x0 got %b exp 0000", {fwd_a_sel, fwd_b_sel}); end
      mem_wR = 5'd12; wb_wR = 5'd4; ex_rs1 = 5'd4; ex_rs2 = 5'd12;
      #1;
      checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1001) begin errors++; $display("FAIL fwd_mix got %b exp 1001", {fwd_a_sel, fwd_b_sel}); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch_priority();
      test_dram_wait();
      test_back_to_back();
      test_pending_flush();
      test_timeout();
      test_saturation();
      test_forwarding();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
